// File: rtl/fpu_arbiter.sv
// Round-robin arbiter that time-sequences a shared FPU adder with no handshake.
// Operands are held for HOLD_CYCLES, then the FPU result is sampled and returned.
module fpu_arbiter #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 80,
    localparam int ID_W       = $clog2(N_REQ)
) (
    input  logic                  clock_100Khz,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_op_a,
    input  logic [32*N_REQ-1:0]   req_op_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic [3:0]            rsp_status,
    output logic                  busy,
    output logic [31:0]           fpu_op_a,
    output logic [31:0]           fpu_op_b,
    input  logic [31:0]           fpu_data_in,
    input  logic [3:0]            fpu_status_in
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [ID_W-1:0]  r_ptr;
    logic [7:0]       r_cnt;
    logic [ID_W-1:0]  r_rsp_id;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_data;
    logic [3:0]       r_rsp_status;
    logic [31:0]      r_op_a;
    logic [31:0]      r_op_b;

    logic             w_found;
    logic [ID_W-1:0]  w_winner;
    logic [31:0]      w_sel_a;
    logic [31:0]      w_sel_b;
    logic [ID_W-1:0]  w_ptr_next;

    // Search starts at r_ptr so the last winner has lowest priority.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && req_valid[(int'(r_ptr) + k) % N_REQ]) begin
                w_found  = 1'b1;
                w_winner = ID_W'((int'(r_ptr) + k) % N_REQ);
            end
        end
    end

    assign w_sel_a    = req_op_a[32*int'(w_winner) +: 32];
    assign w_sel_b    = req_op_b[32*int'(w_winner) +: 32];
    assign w_ptr_next = (r_rsp_id == ID_W'(N_REQ - 1)) ? '0 : r_rsp_id + 1'b1;

    always_comb begin
        req_ready = '0;
        if (r_state == S_IDLE && w_found)
            req_ready[w_winner] = 1'b1;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_found) w_next = S_HOLD;
            S_HOLD:  if (r_cnt == 8'd0) w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_rsp_id     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_status <= 4'd2;
            r_op_a       <= '0;
            r_op_b       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_op_a   <= w_sel_a;
                        r_op_b   <= w_sel_b;
                        r_rsp_id <= w_winner;
                        r_cnt    <= 8'(HOLD_CYCLES - 1);
                    end
                end
                S_HOLD: begin
                    // FPU output is trusted only at the final edge of the window.
                    if (r_cnt == 8'd0) begin
                        r_rsp_data   <= fpu_data_in;
                        r_rsp_status <= fpu_status_in;
                        r_rsp_valid  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= w_ptr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;
    assign rsp_status = r_rsp_status;
    assign busy       = (r_state != S_IDLE);
    assign fpu_op_a   = r_op_a;
    assign fpu_op_b   = r_op_b;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a behavioural FPU stub driven by the bench.
// Uses a short hold window so cycle-exact checks stay compact.
module tb_fpu_arbiter;

    localparam int N  = 4;
    localparam int H  = 10;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] op_a;
    logic [32*N-1:0] op_b;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [31:0]     rsp_data;
    logic [3:0]      rsp_status;
    logic            busy;
    logic [31:0]     fpu_op_a;
    logic [31:0]     fpu_op_b;
    logic [31:0]     fpu_data;
    logic [3:0]      fpu_status;

    int total = 0;
    int bad   = 0;

    fpu_arbiter #(.N_REQ(N), .HOLD_CYCLES(H)) dut (
        .clock_100Khz (clk),
        .reset        (rst_n),
        .req_valid    (req_valid),
        .req_op_a     (op_a),
        .req_op_b     (op_b),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_status   (rsp_status),
        .busy         (busy),
        .fpu_op_a     (fpu_op_a),
        .fpu_op_b     (fpu_op_b),
        .fpu_data_in  (fpu_data),
        .fpu_status_in(fpu_status)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] d0;
        logic        seen;
        int          n;

        rst_n      = 1'b0;
        req_valid  = '0;
        op_a       = '0;
        op_b       = '0;
        rsp_ready  = 1'b0;
        fpu_data   = 32'h4000_0000;
        fpu_status = 4'd2;
        #12;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_status", 32'(rsp_status), 32'd2);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_op_a", fpu_op_a, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // single request from requester 2
        op_a[64 +: 32] = 32'h3FE0_0000;
        op_b[64 +: 32] = 32'h3FE0_0000;
        req_valid = 4'b0100;
        #1;
        chk("t2_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        #1;
        chk("t2_grant_once", 32'(req_ready), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_op_a", fpu_op_a, 32'h3FE0_0000);
        chk("t2_op_b", fpu_op_b, 32'h3FE0_0000);
        repeat (H - 1) tick();
        chk("t2_not_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t2_rsp_id", 32'(rsp_id), 32'd2);
        chk("t2_rsp_data", rsp_data, 32'h4000_0000);
        chk("t2_rsp_status", 32'(rsp_status), 32'd2);

        // backpressure while requester 0 waits
        req_valid = 4'b0001;
        fpu_data  = 32'hDEAD_BEEF;
        seen      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!rsp_valid || rsp_data != 32'h4000_0000 ||
                rsp_id != 2'd2 || req_ready != '0)
                seen = 1'b1;
        end
        chk("t4_stable", 32'(seen), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("t4_valid_fall", 32'(rsp_valid), 32'd0);
        chk("t4_idle_grant", 32'(req_ready), 32'b0001);

        // sample point: value present at the cnt==0 edge only
        op_a[0 +: 32] = 32'h1111_1111;
        fpu_data   = 32'hAAAA_0000;
        fpu_status = 4'd0;
        tick();
        req_valid = '0;
        chk("t5_op_a", fpu_op_a, 32'h1111_1111);
        repeat (H - 1) tick();
        fpu_data   = 32'hBBBB_0001;
        fpu_status = 4'd3;
        tick();
        fpu_data   = 32'hCCCC_0002;
        fpu_status = 4'd1;
        chk("t5_valid", 32'(rsp_valid), 32'd1);
        chk("t5_id", 32'(rsp_id), 32'd0);
        chk("t5_data", rsp_data, 32'hBBBB_0001);
        chk("t5_status", 32'(rsp_status), 32'd3);
        tick();
        chk("t5_data_hold", rsp_data, 32'hBBBB_0001);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // reset mid-hold: ptr is now 1, so requester 1 wins
        op_a[32 +: 32] = 32'h5555_AAAA;
        req_valid = 4'b1111;
        #1;
        chk("t1_ptr_grant", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        chk("t1_op_a", fpu_op_a, 32'h5555_AAAA);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_op_a_clr", fpu_op_a, 32'd0);
        chk("t1_status", 32'(rsp_status), 32'd2);
        chk("t1_valid", 32'(rsp_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen = 1'b0;
        repeat (H + 5) begin
            tick();
            if (rsp_valid || busy) seen = 1'b1;
        end
        chk("t1_no_stale", 32'(seen), 32'd0);

        // round robin from ptr 0, all requesting, consumer always ready
        for (int r = 0; r < N; r++)
            op_a[32*r +: 32] = 32'h1000_0000 + 32'(r);
        fpu_data  = 32'h4000_0000;
        req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            d0 = 32'(1) << (g % N);
            chk($sformatf("t3_grant%0d", g), 32'(req_ready), d0);
            tick();
            chk($sformatf("t3_op%0d", g), fpu_op_a,
                32'h1000_0000 + 32'(g % N));
            if (g < 4) begin
                n = 1;
                while (req_ready == '0 && n < 200) begin
                    tick();
                    n++;
                end
                chk($sformatf("t3_spacing%0d", g), 32'(n), 32'(H + 2));
            end
        end
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
